sd_axi_burst_writer: RTL and testbench

// - Drains one 1 KiB ping-pong buffer half (256 x 32b words) to system memory over an AXI4 write-only master.
// - Sits directly downstream of the ping-pong buffer in sd_controller.
// - Reads words through the buffer read port, splits the block into INCR bursts that never cross 4 KiB, and pulses done so the top flips buffer halves.

---
 rtl/sd_axi_pkg.sv | 31 +++
 rtl/sd_axi_wdata_prefetch.sv | 110 +++++++++++
 rtl/sd_axi_burst_writer.sv | 152 +++++++++++++++
 tb/tb_sd_axi_burst_writer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_axi_pkg.sv
// Shared AXI encodings, the burst-writer FSM state type and the burst sizing helper.
package sd_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [2:0] AXI_SIZE_4B      = 3'b010;
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;
  localparam logic [3:0] AXI_STRB_ALL     = 4'hF;
  localparam int unsigned BEATS_W         = 9;

  typedef enum logic [2:0] {IDLE, AW, W, B, DONE, HOLD} wr_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_req_t;

  // Largest burst that respects the beat cap, the words remaining and the next 4 KiB boundary.
  function automatic logic [BEATS_W-1:0] calc_beats(input logic [11:0] addr_lo,
                                                    input logic [31:0] words_left,
                                                    input logic [31:0] max_beats);
    logic [31:0] room;
    logic [31:0] n;
    room = 32'((13'h1000 - {1'b0, addr_lo}) >> 2);
    n    = max_beats;
    if (words_left < n) n = words_left;
    if (room < n) n = room;
    return BEATS_W'(n);
  endfunction

endpackage

// File: rtl/sd_axi_wdata_prefetch.sv
// Buffer read issue plus a 2-entry write-data queue; keeps W fed at one beat per cycle.
module sd_axi_wdata_prefetch
  import sd_axi_pkg::*;
#(
  parameter int unsigned BUF_AW = 8
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                block_start,
  input  logic                load,
  input  logic [BEATS_W-1:0]  load_beats,
  input  logic                w_phase_next,
  output logic [BUF_AW-1:0]   buffer_addr,
  input  logic [31:0]         buffer_data,
  input  logic                wready,
  output logic                wvalid,
  output logic [31:0]         wdata,
  output logic                wlast
);

  logic [BUF_AW-1:0]  word_ptr_q;
  logic [BEATS_W-1:0] issue_left_q;
  logic               rd_pend_q;
  logic               rd_last_q;
  logic [1:0]         count_q;
  logic [1:0]         count_d;
  logic [31:0]        e0_data_q;
  logic [31:0]        e1_data_q;
  logic               e0_last_q;
  logic               e1_last_q;
  logic               wvalid_q;
  logic               pop_c;
  logic               push_c;
  logic               issue_c;
  logic [2:0]         occ_c;

  // A beat leaving this cycle frees its slot, which is what sustains full throughput.
  always_comb begin
    pop_c   = wvalid_q & wready;
    push_c  = rd_pend_q;
    occ_c   = 3'(count_q) + 3'(rd_pend_q) - 3'(pop_c);
    issue_c = (issue_left_q != '0) && (occ_c < 3'd2);
    count_d = 2'(count_q + 2'(push_c) - 2'(pop_c));
  end

  // Read issue: word pointer, reads left in the current burst, and the in-flight read tag.
  always_ff @(posedge aclk) begin
    if (areset) begin
      word_ptr_q   <= '0;
      issue_left_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_last_q    <= 1'b0;
    end else begin
      if (block_start) word_ptr_q <= '0;
      else             word_ptr_q <= word_ptr_q + BUF_AW'(issue_c);
      if (load) issue_left_q <= load_beats;
      else      issue_left_q <= issue_left_q - BEATS_W'(issue_c);
      rd_pend_q <= issue_c;
      rd_last_q <= issue_c && (issue_left_q == BEATS_W'(1));
    end
  end

  // Two-entry queue; entry 0 always drives the W channel directly.
  always_ff @(posedge aclk) begin
    if (areset) begin
      count_q   <= '0;
      e0_data_q <= '0;
      e1_data_q <= '0;
      e0_last_q <= 1'b0;
      e1_last_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      wvalid_q <= (count_d != 2'd0) && w_phase_next;
      case ({push_c, pop_c})
        2'b10: begin
          if (count_q == 2'd0) begin
            e0_data_q <= buffer_data;
            e0_last_q <= rd_last_q;
          end else begin
            e1_data_q <= buffer_data;
            e1_last_q <= rd_last_q;
          end
        end
        2'b01: begin
          e0_data_q <= e1_data_q;
          e0_last_q <= e1_last_q;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            e0_data_q <= buffer_data;
            e0_last_q <= rd_last_q;
          end else begin
            e0_data_q <= e1_data_q;
            e0_last_q <= e1_last_q;
            e1_data_q <= buffer_data;
            e1_last_q <= rd_last_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign buffer_addr = word_ptr_q;
  assign wvalid      = wvalid_q;
  assign wdata       = e0_data_q;
  assign wlast       = e0_last_q;

endmodule

// File: rtl/sd_axi_burst_writer.sv
// Drains one ping-pong buffer half to memory as AXI4 INCR bursts that never cross 4 KiB.
module sd_axi_burst_writer
  import sd_axi_pkg::*;
#(
  parameter int unsigned BUF_AW      = 8,
  parameter int unsigned BURST_BEATS = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start,
  input  logic [31:0]       initial_addr,
  output logic [BUF_AW-1:0] buffer_addr,
  input  logic [31:0]       buffer_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic [31:0]       axi_awaddr,
  output logic [2:0]        axi_awprot,
  output logic [1:0]        axi_awburst,
  output logic [7:0]        axi_awlen,
  output logic [2:0]        axi_awsize,
  output logic              axi_wvalid,
  input  logic              axi_wready,
  output logic [31:0]       axi_wdata,
  output logic [3:0]        axi_wstrb,
  output logic              axi_wlast,
  input  logic              axi_bvalid,
  output logic              axi_bready,
  input  logic [1:0]        axi_bresp
);

  localparam int unsigned WL_W        = BUF_AW + 1;
  localparam int unsigned BLOCK_WORDS = 2 ** BUF_AW;

  wr_state_e          state_q;
  wr_state_e          state_d;
  logic [31:0]        addr_q;
  logic [31:0]        addr_d;
  logic [WL_W-1:0]    words_left_q;
  logic [WL_W-1:0]    words_left_d;
  logic [BEATS_W-1:0] beats_q;
  logic [BEATS_W-1:0] beats_d;
  aw_req_t            aw_q;
  logic               awvalid_q;
  logic               bready_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               aw_fire_c;
  logic               w_last_fire_c;
  logic               b_fire_c;
  logic               load_c;
  logic               block_start_c;

  // Next state plus block address/count bookkeeping; a burst is sized on entry to AW.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    words_left_d  = words_left_q;
    block_start_c = 1'b0;
    aw_fire_c     = axi_awvalid & axi_awready;
    w_last_fire_c = axi_wvalid & axi_wready & axi_wlast;
    b_fire_c      = axi_bvalid & axi_bready;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d        = initial_addr;
          words_left_d  = WL_W'(BLOCK_WORDS);
          block_start_c = 1'b1;
          state_d       = AW;
        end
      end
      AW:   if (aw_fire_c) state_d = W;
      W:    if (w_last_fire_c) state_d = B;
      B: begin
        if (b_fire_c) begin
          addr_d       = addr_q + (32'(beats_q) << 2);
          words_left_d = words_left_q - WL_W'(beats_q);
          state_d      = (words_left_d != '0) ? AW : DONE;
        end
      end
      DONE:    state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    load_c  = (state_d == AW) && (state_q != AW);
    beats_d = load_c ? calc_beats(addr_d[11:0], 32'(words_left_d), 32'(BURST_BEATS)) : beats_q;
  end

  always_ff @(posedge aclk) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Registered datapath and AXI/status outputs, all derived from the next state.
  always_ff @(posedge aclk) begin
    if (areset) begin
      addr_q       <= '0;
      words_left_q <= '0;
      beats_q      <= '0;
      aw_q         <= '0;
      awvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
      beats_q      <= beats_d;
      if (load_c) begin
        aw_q.addr <= addr_d;
        aw_q.len  <= 8'(beats_d - BEATS_W'(1));
      end
      awvalid_q <= (state_d == AW);
      bready_q  <= (state_d == B);
      busy_q    <= (state_d == AW) || (state_d == W) || (state_d == B);
      done_q    <= (state_d == DONE);
      if (b_fire_c && (axi_bresp != AXI_RESP_OKAY)) err_q <= 1'b1;
    end
  end

  sd_axi_wdata_prefetch #(.BUF_AW(BUF_AW)) u_prefetch (
    .aclk         (aclk),
    .areset       (areset),
    .block_start  (block_start_c),
    .load         (load_c),
    .load_beats   (beats_d),
    .w_phase_next (state_d == W),
    .buffer_addr  (buffer_addr),
    .buffer_data  (buffer_data),
    .wready       (axi_wready),
    .wvalid       (axi_wvalid),
    .wdata        (axi_wdata),
    .wlast        (axi_wlast)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign axi_awvalid = awvalid_q;
  assign axi_awaddr  = aw_q.addr;
  assign axi_awlen   = aw_q.len;
  assign axi_awprot  = AXI_PROT_DEFAULT;
  assign axi_awburst = AXI_BURST_INCR;
  assign axi_awsize  = AXI_SIZE_4B;
  assign axi_wstrb   = AXI_STRB_ALL;
  assign axi_bready  = bready_q;

endmodule

// File: tb/tb_sd_axi_burst_writer.sv
// Directed bench for sd_axi_burst_writer: AXI slave and sync buffer models, scenario tasks.
module tb_sd_axi_burst_writer;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start;
  logic [31:0] initial_addr;
  logic [7:0]  buffer_addr;
  logic [31:0] buffer_data;
  logic        busy, done, err;
  logic        axi_awvalid, axi_awready;
  logic [31:0] axi_awaddr;
  logic [2:0]  axi_awprot;
  logic [1:0]  axi_awburst;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic        axi_wvalid, axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_bvalid, axi_bready;
  logic [1:0]  axi_bresp;

  int          errors = 0;
  int          checks = 0;
  logic        err_exp = 1'b0;
  logic [31:0] mem [256];
  logic [31:0] aw_addr_log [64];
  logic [7:0]  aw_len_log [64];

  always #5 aclk = ~aclk;

  // Buffer read port: one cycle of latency.
  always @(posedge aclk) buffer_data <= mem[buffer_addr];

  sd_axi_burst_writer #(.BUF_AW(8), .BURST_BEATS(16)) dut (
    .aclk(aclk), .areset(areset), .start(start), .initial_addr(initial_addr),
    .buffer_addr(buffer_addr), .buffer_data(buffer_data),
    .busy(busy), .done(done), .err(err),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awprot(axi_awprot), .axi_awburst(axi_awburst), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp)
  );

  task automatic fill_mem(input logic [31:0] base);
    for (int i = 0; i < 256; i++) mem[i] = base + 32'(i);
  endtask

  // Acts as the AXI slave for one block; stall is the percentage of cycles each ready/valid is withheld.
  task automatic run_block(input int stall, input int err_burst, input logic [31:0] data_base,
                           input bit keep_start, output int nb, output int nbeats, output int ndone);
    int          beat_in, nb_resp;
    logic [7:0]  cur_len, prev_len;
    logic [31:0] prev_addr;
    bit          pend_b, b_fire, prev_stall;
    nb = 0; nbeats = 0; ndone = 0; beat_in = 0; nb_resp = 0; cur_len = 8'd0;
    pend_b = 0; b_fire = 0; prev_stall = 0; prev_addr = '0; prev_len = '0;
    for (int cyc = 0; cyc < 4000 && ndone == 0; cyc++) begin
      @(negedge aclk);
      if (cyc == 0) begin
        if (!keep_start) start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got=%b exp=1", busy); end
      end
      if (b_fire) begin axi_bvalid = 1'b0; axi_bresp = 2'b00; b_fire = 0; end
      checks++;
      if (err !== err_exp) begin errors++; $display("FAIL err_sticky cyc=%0d got=%b exp=%b", cyc, err, err_exp); end
      if (done === 1'b1) ndone++;
      if (prev_stall) begin
        checks++;
        if (axi_awvalid !== 1'b1 || axi_awaddr !== prev_addr || axi_awlen !== prev_len) begin
          errors++;
          $display("FAIL aw_stable got=%b/%h/%0d exp=1/%h/%0d", axi_awvalid, axi_awaddr, axi_awlen, prev_addr, prev_len);
        end
      end
      axi_awready = (int'($urandom_range(99)) >= stall);
      prev_stall  = axi_awvalid && !axi_awready;
      prev_addr   = axi_awaddr;
      prev_len    = axi_awlen;
      if (axi_awvalid && axi_awready) begin
        if (nb < 64) begin aw_addr_log[nb] = axi_awaddr; aw_len_log[nb] = axi_awlen; end
        cur_len = axi_awlen; beat_in = 0; nb++;
      end
      if (pend_b && !axi_bvalid && (int'($urandom_range(99)) >= stall)) begin
        axi_bvalid = 1'b1;
        axi_bresp  = (nb_resp == err_burst) ? 2'b10 : 2'b00;
      end
      if (axi_bvalid && axi_bready) begin
        b_fire = 1; pend_b = 0; nb_resp++;
        if (axi_bresp != 2'b00) err_exp = 1'b1;
      end
      axi_wready = (int'($urandom_range(99)) >= stall);
      if (axi_wvalid && axi_wready) begin
        checks++;
        if (axi_wdata !== data_base + 32'(nbeats)) begin
          errors++; $display("FAIL wdata beat=%0d got=%h exp=%h", nbeats, axi_wdata, data_base + 32'(nbeats));
        end
        checks++;
        if (axi_wlast !== (beat_in == int'(cur_len))) begin
          errors++; $display("FAIL wlast beat=%0d got=%b exp=%b", nbeats, axi_wlast, beat_in == int'(cur_len));
        end
        nbeats++; beat_in++;
        if (axi_wlast) pend_b = 1;
      end
    end
    if (ndone == 0) begin
      checks++; errors++; $display("FAIL done_timeout got=0 exp=1 bursts=%0d beats=%0d", nb, nbeats);
    end
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1; start = 1'b0; initial_addr = '0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
    fill_mem(32'h0);
    repeat (3) @(negedge aclk);
    checks++; if (axi_awvalid !== 1'b0) begin errors++; $display("FAIL rst_awvalid got=%b exp=0", axi_awvalid); end
    checks++; if (axi_wvalid !== 1'b0) begin errors++; $display("FAIL rst_wvalid got=%b exp=0", axi_wvalid); end
    checks++; if (axi_bready !== 1'b0) begin errors++; $display("FAIL rst_bready got=%b exp=0", axi_bready); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL rst_status got=%b exp=000", {busy, done, err}); end
    checks++; if (buffer_addr !== 8'd0) begin errors++; $display("FAIL rst_buffer_addr got=%0d exp=0", buffer_addr); end
    checks++;
    if (axi_awburst !== 2'b01 || axi_awsize !== 3'b010 || axi_awprot !== 3'b000 || axi_wstrb !== 4'hF) begin
      errors++; $display("FAIL rst_consts got=%b/%b/%b/%h exp=01/010/000/f", axi_awburst, axi_awsize, axi_awprot, axi_wstrb);
    end
    areset = 1'b0;
    err_exp = 1'b0;
    repeat (2) @(negedge aclk);
  endtask

  task automatic test_aligned();
    int nb, nbeats, nd;
    fill_mem(32'h0);
    initial_addr = 32'h8000_0000;
    start = 1'b1;
    run_block(0, -1, 32'h0, 1'b0, nb, nbeats, nd);
    checks++; if (nb !== 16) begin errors++; $display("FAIL aligned_bursts got=%0d exp=16", nb); end
    checks++; if (nbeats !== 256) begin errors++; $display("FAIL aligned_beats got=%0d exp=256", nbeats); end
    checks++; if (aw_addr_log[0] !== 32'h8000_0000) begin errors++; $display("FAIL aligned_addr0 got=%h exp=80000000", aw_addr_log[0]); end
    checks++; if (aw_addr_log[1] !== 32'h8000_0040) begin errors++; $display("FAIL aligned_addr1 got=%h exp=80000040", aw_addr_log[1]); end
    checks++; if (aw_addr_log[15] !== 32'h8000_03C0) begin errors++; $display("FAIL aligned_addr15 got=%h exp=800003c0", aw_addr_log[15]); end
    checks++; if (aw_len_log[0] !== 8'd15 || aw_len_log[15] !== 8'd15) begin
      errors++; $display("FAIL aligned_len got=%0d/%0d exp=15/15", aw_len_log[0], aw_len_log[15]);
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL aligned_err got=%b exp=0", err); end
    @(negedge aclk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_single got=%b/%b exp=0/0", done, busy); end
    repeat (2) @(negedge aclk);
  endtask

  task automatic test_4k_boundary();
    int nb, nbeats, nd;
    fill_mem(32'h5A00_0000);
    initial_addr = 32'h0000_0FC0;
    start = 1'b1;
    run_block(0, -1, 32'h5A00_0000, 1'b0, nb, nbeats, nd);
    checks++; if (aw_addr_log[0] !== 32'h0FC0 || aw_len_log[0] !== 8'd15) begin
      errors++; $display("FAIL b4k_fc0_first got=%h/%0d exp=00000fc0/15", aw_addr_log[0], aw_len_log[0]);
    end
    checks++; if (aw_addr_log[1] !== 32'h1000) begin errors++; $display("FAIL b4k_fc0_second got=%h exp=00001000", aw_addr_log[1]); end
    checks++; if (nb !== 16 || nbeats !== 256) begin errors++; $display("FAIL b4k_fc0_count got=%0d/%0d exp=16/256", nb, nbeats); end
    repeat (3) @(negedge aclk);
    initial_addr = 32'h0000_0FF8;
    start = 1'b1;
    run_block(0, -1, 32'h5A00_0000, 1'b0, nb, nbeats, nd);
    checks++; if (aw_addr_log[0] !== 32'h0FF8 || aw_len_log[0] !== 8'd1) begin
      errors++; $display("FAIL b4k_ff8_first got=%h/%0d exp=00000ff8/1", aw_addr_log[0], aw_len_log[0]);
    end
    checks++; if (aw_addr_log[1] !== 32'h1000 || aw_len_log[1] !== 8'd15) begin
      errors++; $display("FAIL b4k_ff8_second got=%h/%0d exp=00001000/15", aw_addr_log[1], aw_len_log[1]);
    end
    checks++; if (aw_addr_log[16] !== 32'h13C0 || aw_len_log[16] !== 8'd13) begin
      errors++; $display("FAIL b4k_ff8_tail got=%h/%0d exp=000013c0/13", aw_addr_log[16], aw_len_log[16]);
    end
    checks++; if (nb !== 17 || nbeats !== 256) begin errors++; $display("FAIL b4k_ff8_count got=%0d/%0d exp=17/256", nb, nbeats); end
    repeat (3) @(negedge aclk);
  endtask

  task automatic test_stalls();
    int nb, nbeats, nd;
    fill_mem(32'h1000_0000);
    initial_addr = 32'h0000_1F80;
    start = 1'b1;
    run_block(30, -1, 32'h1000_0000, 1'b0, nb, nbeats, nd);
    checks++; if (nb !== 16 || nbeats !== 256) begin errors++; $display("FAIL stall_count got=%0d/%0d exp=16/256", nb, nbeats); end
    checks++; if (aw_addr_log[1] !== 32'h1FC0 || aw_addr_log[2] !== 32'h2000) begin
      errors++; $display("FAIL stall_addr got=%h/%h exp=00001fc0/00002000", aw_addr_log[1], aw_addr_log[2]);
    end
    checks++; if (nd !== 1) begin errors++; $display("FAIL stall_done got=%0d exp=1", nd); end
    repeat (3) @(negedge aclk);
  endtask

  task automatic test_bresp_err();
    int nb, nbeats, nd;
    fill_mem(32'hC0DE_0000);
    initial_addr = 32'h2000_0000;
    start = 1'b1;
    run_block(0, 3, 32'hC0DE_0000, 1'b0, nb, nbeats, nd);
    checks++; if (nb !== 16 || nbeats !== 256) begin errors++; $display("FAIL berr_count got=%0d/%0d exp=16/256", nb, nbeats); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL berr_err got=%b exp=1", err); end
    @(negedge aclk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL berr_done_once got=%b exp=0", done); end
    repeat (2) @(negedge aclk);
    start = 1'b1;
    run_block(0, -1, 32'hC0DE_0000, 1'b0, nb, nbeats, nd);
    checks++; if (err !== 1'b1 || nbeats !== 256) begin errors++; $display("FAIL berr_second got=%b/%0d exp=1/256", err, nbeats); end
    repeat (3) @(negedge aclk);
  endtask

  task automatic test_back_to_back();
    int nb, nbeats, nd;
    fill_mem(32'h0000_0100);
    initial_addr = 32'h4000_0000;
    start = 1'b1;
    run_block(0, -1, 32'h0000_0100, 1'b1, nb, nbeats, nd);
    checks++; if (nbeats !== 256) begin errors++; $display("FAIL b2b_beats got=%0d exp=256", nbeats); end
    @(negedge aclk);
    checks++; if (axi_awvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_hold got=%b/%b exp=0/0", axi_awvalid, busy); end
    @(negedge aclk);
    checks++; if (axi_awvalid !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", axi_awvalid); end
    @(negedge aclk);
    checks++; if (axi_awvalid !== 1'b1 || axi_awaddr !== 32'h4000_0000 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_restart got=%b/%h/%b exp=1/40000000/1", axi_awvalid, axi_awaddr, busy);
    end
  endtask

  task automatic test_reset_mid_w();
    bit seen_w;
    seen_w = 0;
    start = 1'b0;
    axi_awready = 1'b1;
    for (int i = 0; i < 20 && !seen_w; i++) begin
      @(negedge aclk);
      axi_awready = 1'b0;
      if (axi_wvalid === 1'b1) seen_w = 1;
    end
    checks++; if (!seen_w) begin errors++; $display("FAIL rstw_reach_w got=0 exp=1"); end
    areset = 1'b1;
    @(negedge aclk);
    checks++; if ({axi_awvalid, axi_wvalid, axi_bready} !== 3'b000) begin
      errors++; $display("FAIL rstw_axi got=%b exp=000", {axi_awvalid, axi_wvalid, axi_bready});
    end
    checks++; if ({busy, done, err} !== 3'b000 || buffer_addr !== 8'd0) begin
      errors++; $display("FAIL rstw_status got=%b/%0d exp=000/0", {busy, done, err}, buffer_addr);
    end
    areset = 1'b0;
    err_exp = 1'b0;
    repeat (3) @(negedge aclk);
    checks++; if (axi_awvalid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstw_quiet got=%b/%b exp=0/0", axi_awvalid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_4k_boundary();
    test_stalls();
    test_bresp_err();
    test_back_to_back();
    test_reset_mid_w();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
